bus_packer: RTL



---
 rtl/bus_packer_if.sv | 34 +++
 rtl/bus_packer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bus_packer_if.sv
// Handshake bundle for bus_packer: a narrow input stream, a packed output word,
// a flush strobe and the fill count.
//   clear                 flush request (driven by the producer side)
//   in_valid/in_data      narrow word offered to the packer
//   in_ready              packer takes in_data this cycle
//   out_valid/out_data    complete packed word, slot 0 in the LSBs
//   out_ready             consumer takes out_data this cycle
//   count                 number of slots filled (0..CHANNELS)
// Modports: master = the side that feeds and drains the packer, slave = the packer.
interface bus_packer_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned BUS_SIZE = 8
);
  localparam int unsigned CntW = $clog2(CHANNELS + 1);

  logic                         clear;
  logic                         in_valid;
  logic [BUS_SIZE-1:0]          in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic [CHANNELS*BUS_SIZE-1:0] out_data;
  logic                         out_ready;
  logic [CntW-1:0]              count;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/bus_packer.sv
// Collects CHANNELS words of BUS_SIZE bits, one per input handshake, into one
// packed word. Slot k sits at out_data[k*BUS_SIZE +: BUS_SIZE] in acceptance order.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    bus_packer_if.slave (clear, in_*, out_*, count)
// Optional feature: define BUS_PACKER_BACK_TO_BACK_EN to let the packer accept a
// new word in the same cycle a full word is transferred out (no idle cycle).
module bus_packer #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned BUS_SIZE = 8
) (
  input  logic        clk,
  input  logic        reset,
  bus_packer_if.slave bus
);

  localparam int unsigned Width = CHANNELS * BUS_SIZE;
  localparam int unsigned CntW  = $clog2(CHANNELS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(CHANNELS - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic {StFill, StFull} state_e;

  state_e            state_q, state_d;
  logic [Width-1:0]  data_q, data_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              in_ready;
  logic              accept;
  logic              xfer;

  assign accept = bus.in_valid && in_ready;
  assign xfer   = (state_q == StFull) && bus.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = StFill;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept && (count_q == LastCnt)) state_d = StFull;
        end
        StFull: begin
          if (xfer) begin
            state_d = StFill;
`ifdef BUS_PACKER_BACK_TO_BACK_EN
            // A single-slot word refills completely on the same edge.
            if (accept && (CHANNELS == 1)) state_d = StFull;
`endif
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  // Output logic
  always_comb begin
`ifdef BUS_PACKER_BACK_TO_BACK_EN
    in_ready = (state_q == StFill) || bus.out_ready;
`else
    in_ready = (state_q == StFill);
`endif
  end

  // Packed data and fill count
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (bus.clear) begin
      data_d  = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
              if (count_q == CntW'(k)) data_d[k*BUS_SIZE +: BUS_SIZE] = bus.in_data;
            end
            count_d = count_q + OneCnt;
          end
        end
        StFull: begin
          if (xfer) begin
            data_d  = '0;
            count_d = '0;
`ifdef BUS_PACKER_BACK_TO_BACK_EN
            // The new word starts the next packed word in slot 0.
            if (accept) begin
              data_d[BUS_SIZE-1:0] = bus.in_data;
              count_d              = OneCnt;
            end
`endif
          end
        end
        default: begin
          data_d  = '0;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  // out_valid is the state flop itself, so it is a registered output.
  assign bus.out_valid = (state_q == StFull);
  assign bus.out_data  = data_q;
  assign bus.count     = count_q;

endmodule
